trapez_cfg_sequencer: RTL and testbench

Run-time configuration sequencer for the multi-channel trapezoidal shaper. Accepts per-channel K, L, M_1, M_2 updates over a valid/ready handshake and validates them. Applies each update safely: gates the target channel's input, waits for the shaper pipeline to drain, loads the new constants, clears the channel's delay lines and accumulators, then re-enables it. Sits between the register/control interface and the shaper datapath; the shaper reads its constants only from this block.

---
 rtl/trapez_cfg_sequencer.sv | 200 ++++++++++++++++++++
 tb/tb_trapez_cfg_sequencer.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/trapez_cfg_sequencer.sv
// Run-time K/L/M_1/M_2 update sequencer for the multi-channel trapezoidal shaper.
// Build option: define TRAPEZ_CFG_CHECK_EN to enable request validation and rejection.
module trapez_cfg_sequencer #(
  parameter int CHANNEL_SIZE    = 2,
  parameter int CONSTANT_SIZE   = 8,
  parameter int SHIFT_REG_SIZE  = 300,
  parameter int PIPELINE_STAGES = 8,
  parameter int DEFAULT_K       = 1,
  parameter int DEFAULT_L       = 2,
  parameter int DEFAULT_M_1     = 2,
  parameter int DEFAULT_M_2     = 4,
  localparam int CW = (CHANNEL_SIZE > 1) ? $clog2(CHANNEL_SIZE) : 1,
  localparam int CS = CONSTANT_SIZE
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [CW-1:0]            cfg_channel,
  input  logic [CS-1:0]            cfg_k,
  input  logic [CS-1:0]            cfg_l,
  input  logic [CS-1:0]            cfg_m_1,
  input  logic [CS-1:0]            cfg_m_2,
  output logic                     cfg_done,
  output logic                     cfg_error,
  output logic                     busy,
  output logic [CHANNEL_SIZE-1:0]  shaper_enable,
  output logic [CHANNEL_SIZE-1:0]  shaper_clear,
  output logic [CHANNEL_SIZE*CS-1:0] k_out,
  output logic [CHANNEL_SIZE*CS-1:0] l_out,
  output logic [CHANNEL_SIZE*CS-1:0] m_1_out,
  output logic [CHANNEL_SIZE*CS-1:0] m_2_out,
  output logic [2:0]               dbg_state
);

  // Handshake: a request transfers on a rising edge where cfg_valid && cfg_ready;
  // cfg_ready is high only in IDLE, so exactly one update is ever in flight.

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_GATE, S_APPLY, S_FLUSH, S_RELEASE
  } state_t;

  localparam logic [CS:0] SRS_W   = (CS+1)'(SHIFT_REG_SIZE);
  localparam logic [CS:0] GATE_LD = (CS+1)'(PIPELINE_STAGES - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] stg_ch_q, stg_ch_d;
  logic [CS-1:0] stg_k_q, stg_k_d, stg_l_q, stg_l_d;
  logic [CS-1:0] stg_m1_q, stg_m1_d, stg_m2_q, stg_m2_d;
  logic [CS:0]   cnt_q, cnt_d;
  logic [CS-1:0] k_q  [CHANNEL_SIZE];
  logic [CS-1:0] k_d  [CHANNEL_SIZE];
  logic [CS-1:0] l_q  [CHANNEL_SIZE];
  logic [CS-1:0] l_d  [CHANNEL_SIZE];
  logic [CS-1:0] m1_q [CHANNEL_SIZE];
  logic [CS-1:0] m1_d [CHANNEL_SIZE];
  logic [CS-1:0] m2_q [CHANNEL_SIZE];
  logic [CS-1:0] m2_d [CHANNEL_SIZE];

  logic [CS:0]   kl_sum, flush_len, flush_load;
  logic          reject;
  logic [CHANNEL_SIZE-1:0] ch_hit;

  assign kl_sum = {1'b0, stg_k_q} + {1'b0, stg_l_q};

`ifdef TRAPEZ_CFG_CHECK_EN
  localparam logic [CW:0] CH_LIM = (CW+1)'(CHANNEL_SIZE);
  assign flush_len = kl_sum;
  assign reject    = ({1'b0, stg_ch_q} >= CH_LIM) || (stg_k_q == '0) ||
                     (stg_l_q < stg_k_q) || (stg_m2_q == '0) || (kl_sum > SRS_W);
  assign cfg_error = (state_q == S_CHECK) && reject;
`else
  assign flush_len = (kl_sum > SRS_W) ? SRS_W : kl_sum;
  assign reject    = 1'b0;
  assign cfg_error = 1'b0;
`endif

  // Counter is loaded with length-1; a zero-length flush still spends one cycle.
  assign flush_load = (flush_len == '0) ? '0 : flush_len - 1'b1;

  // Out-of-range indices match no channel and therefore touch nothing.
  always_comb begin
    for (int n = 0; n < CHANNEL_SIZE; n++) begin
      ch_hit[n] = (stg_ch_q == CW'(n));
    end
  end

  always_comb begin
    state_d  = state_q;
    stg_ch_d = stg_ch_q;
    stg_k_d  = stg_k_q;
    stg_l_d  = stg_l_q;
    stg_m1_d = stg_m1_q;
    stg_m2_d = stg_m2_q;
    cnt_d    = cnt_q;
    k_d      = k_q;
    l_d      = l_q;
    m1_d     = m1_q;
    m2_d     = m2_q;
    cfg_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cfg_valid) begin
          stg_ch_d = cfg_channel;
          stg_k_d  = cfg_k;
          stg_l_d  = cfg_l;
          stg_m1_d = cfg_m_1;
          stg_m2_d = cfg_m_2;
          state_d  = S_CHECK;
        end
      end
      S_CHECK: begin
        if (reject) begin
          state_d = S_IDLE;
        end else begin
          cnt_d   = GATE_LD;
          state_d = S_GATE;
        end
      end
      S_GATE: begin
        if (cnt_q == '0) state_d = S_APPLY;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_APPLY: begin
        for (int n = 0; n < CHANNEL_SIZE; n++) begin
          if (ch_hit[n]) begin
            k_d[n]  = stg_k_q;
            l_d[n]  = stg_l_q;
            m1_d[n] = stg_m1_q;
            m2_d[n] = stg_m2_q;
          end
        end
        cnt_d   = flush_load;
        state_d = S_FLUSH;
      end
      S_FLUSH: begin
        if (cnt_q == '0) state_d = S_RELEASE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_RELEASE: begin
        cfg_done = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    shaper_enable = '1;
    shaper_clear  = '0;
    k_out   = '0;
    l_out   = '0;
    m_1_out = '0;
    m_2_out = '0;
    for (int n = 0; n < CHANNEL_SIZE; n++) begin
      shaper_enable[n] = !(ch_hit[n] &&
                           (state_q == S_GATE || state_q == S_APPLY || state_q == S_FLUSH));
      shaper_clear[n]  = ch_hit[n] && (state_q == S_APPLY || state_q == S_FLUSH);
      k_out[n*CS +: CS]   = k_q[n];
      l_out[n*CS +: CS]   = l_q[n];
      m_1_out[n*CS +: CS] = m1_q[n];
      m_2_out[n*CS +: CS] = m2_q[n];
    end
  end

  assign cfg_ready = (state_q == S_IDLE) && !reset;
  assign busy      = (state_q != S_IDLE);
  assign dbg_state = state_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      stg_ch_q <= '0;
      stg_k_q  <= '0;
      stg_l_q  <= '0;
      stg_m1_q <= '0;
      stg_m2_q <= '0;
      cnt_q    <= '0;
      for (int n = 0; n < CHANNEL_SIZE; n++) begin
        k_q[n]  <= CS'(DEFAULT_K);
        l_q[n]  <= CS'(DEFAULT_L);
        m1_q[n] <= CS'(DEFAULT_M_1);
        m2_q[n] <= CS'(DEFAULT_M_2);
      end
    end else begin
      state_q  <= state_d;
      stg_ch_q <= stg_ch_d;
      stg_k_q  <= stg_k_d;
      stg_l_q  <= stg_l_d;
      stg_m1_q <= stg_m1_d;
      stg_m2_q <= stg_m2_d;
      cnt_q    <= cnt_d;
      k_q      <= k_d;
      l_q      <= l_d;
      m1_q     <= m1_d;
      m2_q     <= m2_d;
    end
  end

endmodule

// File: tb/tb_trapez_cfg_sequencer.sv
// Bench for trapez_cfg_sequencer: directed and random updates checked against a
// per-request timing/outcome model of the update sequence.
module tb_trapez_cfg_sequencer;

  localparam int PIPE = 8;
  localparam int SRS  = 300;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [0:0]  cfg_channel;
  logic [7:0]  cfg_k, cfg_l, cfg_m_1, cfg_m_2;
  logic        cfg_done, cfg_error, busy;
  logic [1:0]  shaper_enable, shaper_clear;
  logic [15:0] k_out, l_out, m_1_out, m_2_out;
  logic [2:0]  dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: active constants per channel.
  int mk[2], ml[2], mm1[2], mm2[2];
  int nxt_ch, nxt_k, nxt_l, nxt_m1, nxt_m2;

  trapez_cfg_sequencer dut (
    .clk(clk), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_channel(cfg_channel), .cfg_k(cfg_k), .cfg_l(cfg_l),
    .cfg_m_1(cfg_m_1), .cfg_m_2(cfg_m_2), .cfg_done(cfg_done),
    .cfg_error(cfg_error), .busy(busy), .shaper_enable(shaper_enable),
    .shaper_clear(shaper_clear), .k_out(k_out), .l_out(l_out),
    .m_1_out(m_1_out), .m_2_out(m_2_out), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] get_cfg(input int ch);
    return {k_out[ch*8 +: 8], l_out[ch*8 +: 8], m_1_out[ch*8 +: 8], m_2_out[ch*8 +: 8]};
  endfunction

  function automatic logic [31:0] model_cfg(input int ch);
    return {mk[ch][7:0], ml[ch][7:0], mm1[ch][7:0], mm2[ch][7:0]};
  endfunction

  function automatic bit model_reject(input int ch, input int k, input int l, input int m2);
`ifdef TRAPEZ_CFG_CHECK_EN
    return (ch >= 2) || (k == 0) || (l < k) || (m2 == 0) || (k + l > SRS);
`else
    return 1'b0;
`endif
  endfunction

  function automatic int model_len(input int k, input int l);
`ifdef TRAPEZ_CFG_CHECK_EN
    return k + l;
`else
    return (k + l > SRS) ? SRS : k + l;
`endif
  endfunction

  task automatic set_defaults();
    for (int n = 0; n < 2; n++) begin
      mk[n] = 1; ml[n] = 2; mm1[n] = 2; mm2[n] = 4;
    end
  endtask

  task automatic check_all_cfg(input string tag);
    for (int n = 0; n < 2; n++) check($sformatf("%s_cfg_ch%0d", tag, n), get_cfg(n), model_cfg(n));
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after the outcome pulse.
  task automatic do_update(input int ch, input int k, input int l, input int m1,
                           input int m2, input bit keep);
    bit rej;
    int len, err_cyc, done_cyc, en_first, en_cnt, clr_first, clr_cnt;
    bit other_bad, ready_seen;
    logic [31:0] pre, post, old_cfg, new_cfg;
    rej = model_reject(ch, k, l, m2);
    len = model_len(k, l);
    old_cfg = model_cfg(ch);
    new_cfg = {k[7:0], l[7:0], m1[7:0], m2[7:0]};
    err_cyc = -1; done_cyc = -1; en_first = -1; en_cnt = 0; clr_first = -1; clr_cnt = 0;
    other_bad = 0; ready_seen = 0; pre = '1; post = '1;
    cfg_channel = ch[0:0]; cfg_k = k[7:0]; cfg_l = l[7:0]; cfg_m_1 = m1[7:0]; cfg_m_2 = m2[7:0];
    cfg_valid = 1'b1;
    check("ready_at_req", cfg_ready, 1);
    @(posedge clk);
    #1;
    if (keep) begin
      cfg_channel = nxt_ch[0:0]; cfg_k = nxt_k[7:0]; cfg_l = nxt_l[7:0];
      cfg_m_1 = nxt_m1[7:0]; cfg_m_2 = nxt_m2[7:0];
    end else begin
      cfg_valid = 1'b0;
    end
    for (int c = 1; c <= 700; c++) begin
      @(negedge clk);
      if (cfg_error && err_cyc < 0) err_cyc = c;
      if (cfg_done && done_cyc < 0) done_cyc = c;
      if (!shaper_enable[ch]) begin
        if (en_first < 0) en_first = c;
        en_cnt++;
      end
      if (shaper_clear[ch]) begin
        if (clr_first < 0) clr_first = c;
        clr_cnt++;
      end
      if (shaper_enable[1-ch] !== 1'b1 || shaper_clear[1-ch] !== 1'b0) other_bad = 1;
      if (cfg_ready) ready_seen = 1;
      if (c == PIPE + 2) pre = get_cfg(ch);
      if (c == PIPE + 3) post = get_cfg(ch);
      if (cfg_done || cfg_error) break;
    end
    if (rej) begin
      check("err_cycle", err_cyc, 1);
      check("no_done", done_cyc, -1);
      check("rej_no_gate", en_cnt, 0);
      check("rej_no_clear", clr_cnt, 0);
    end else begin
      check("no_err", err_cyc, -1);
      check("done_cycle", done_cyc, PIPE + 3 + len);
      check("gate_first", en_first, 2);
      check("gate_len", en_cnt, PIPE + 1 + len);
      check("clear_first", clr_first, PIPE + 2);
      check("clear_len", clr_cnt, len + 1);
      check("cfg_before_apply", pre, old_cfg);
      check("cfg_after_apply", post, new_cfg);
      mk[ch] = k; ml[ch] = l; mm1[ch] = m1; mm2[ch] = m2;
    end
    check("other_untouched", other_bad, 0);
    check("ready_low_busy", ready_seen, 0);
    check_all_cfg("post_update");
    @(negedge clk);
    check("ready_after", cfg_ready, 1);
    check("busy_after", busy, 0);
  endtask

  initial begin
    int ch, k, l, m1, m2;
    bit done_seen;
    reset = 1'b1; cfg_valid = 1'b0; cfg_channel = '0;
    cfg_k = '0; cfg_l = '0; cfg_m_1 = '0; cfg_m_2 = '0;
    set_defaults();
    repeat (3) @(negedge clk);
    check("ready_in_reset", cfg_ready, 0);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check_all_cfg("reset");
    check("reset_enable", shaper_enable, 2'b11);
    check("reset_clear", shaper_clear, 2'b00);
    check("reset_ready", cfg_ready, 1);
    check("reset_busy", busy, 0);
    check("reset_done", cfg_done, 0);
    check("reset_error", cfg_error, 0);

    do_update(1, 3, 5, 2, 4, 0);
    repeat (2) @(negedge clk);
    do_update(0, 6, 4, 1, 1, 0);
    repeat (2) @(negedge clk);
    do_update(0, 200, 150, 3, 3, 0);
    @(negedge clk);
    do_update(1, 150, 150, 5, 6, 0);
    @(negedge clk);
    do_update(0, 0, 9, 1, 1, 0);
    @(negedge clk);
    do_update(1, 4, 4, 1, 0, 0);
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      ch = $urandom_range(0, 1);
`ifdef TRAPEZ_CFG_CHECK_EN
      k  = $urandom_range(0, 160);
      l  = $urandom_range(0, 160);
      m2 = $urandom_range(0, 3);
`else
      k  = $urandom_range(1, 255);
      l  = $urandom_range(0, 255);
      m2 = $urandom_range(0, 255);
`endif
      m1 = $urandom_range(0, 255);
      do_update(ch, k, l, m1, m2, 0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // Reset during FLUSH of a ch0 update.
    cfg_channel = 1'b0; cfg_k = 8'd10; cfg_l = 8'd20; cfg_m_1 = 8'd7; cfg_m_2 = 8'd9;
    cfg_valid = 1'b1;
    @(posedge clk);
    #1 cfg_valid = 1'b0;
    done_seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (cfg_done) done_seen = 1;
    end
    reset = 1'b1;
    @(negedge clk);
    set_defaults();
    check("abort_busy", busy, 0);
    check("abort_enable", shaper_enable, 2'b11);
    check("abort_clear", shaper_clear, 2'b00);
    check_all_cfg("abort");
    reset = 1'b0;
    @(negedge clk);
    if (cfg_done || cfg_error) done_seen = 1;
    check("abort_no_pulse", done_seen, 0);
    check("abort_ready", cfg_ready, 1);

    // Back-to-back with cfg_valid held across the first cfg_done.
    nxt_ch = 0; nxt_k = 2; nxt_l = 3; nxt_m1 = 1; nxt_m2 = 2;
    do_update(1, 5, 7, 3, 3, 1);
    do_update(nxt_ch, nxt_k, nxt_l, nxt_m1, nxt_m2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
